write_accounter: RTL and testbench
==================================

// Module: write_accounter
// PURPOSE
// - Live-value table (LVT) of the multi-port RAM: records, per address, which write bank holds the latest data.
// - Sits beside the write banks: each write agent owns one bank; this block snoops all write requests.
// - Drives the per-read-agent bank selector consumed by the read switch, in the same cycle as the read address.
// - Runs a post-reset clear sweep, so that every address initially points to bank 0.
// PARAMETERS
// - ADDR_WIDTH    8   address width; table depth = 2**ADDR_WIDTH
// - NB_WRAGENT    2   number of write agents (= number of banks)
// - NB_RDAGENT    2   number of read agents
// - SELECT_WIDTH  (NB_WRAGENT>1 ? $clog2(NB_WRAGENT) : 1)   width of one bank selector
// PORTS
// - aclk       in   1                        clock, rising edge
// - aresetn    in   1                        asynchronous active-low reset
// - ready      out  1                        high once the clear sweep is done; agents must not access before this
// - m_wren     in   NB_WRAGENT               write enable per write agent
// - m_wraddr   in   NB_WRAGENT*ADDR_WIDTH    write address per write agent, agent i at [i*ADDR_WIDTH+:ADDR_WIDTH]
// - m_rden     in   NB_RDAGENT               read enable per read agent
// - m_rdaddr   in   NB_RDAGENT*ADDR_WIDTH    read address per read agent
// - rdselect   out  NB_RDAGENT*SELECT_WIDTH  bank holding the latest data for m_rdaddr of each read agent
// - collision  out  1                        registered pulse: two or more write agents hit one address in the same cycle
// BEHAVIOUR
// - Reset values (async, aresetn=0):
//   - FSM = INIT, sweep counter = 0, ready = 0, collision = 0.
//   - rdselect = 0 while ready = 0.
// - FSM INIT:
//   - Writes 0 to table[counter] each cycle; counter increments by 1.
//   - At counter = 2**ADDR_WIDTH-1: the entry is written, then the FSM goes to RUN.
//   - ready rises on the next cycle, i.e. exactly 2**ADDR_WIDTH cycles after reset release.
//   - m_wren and m_rden are ignored in INIT; the table is untouched by agents.
// - FSM RUN:
//   - Terminal state; only aresetn leaves it.
//   - Reset mid-operation returns to INIT and restarts the full sweep.
// - Write update in RUN:
//   - For each i with m_wren[i]=1: table[m_wraddr_i] <= i at the next rising edge.
//   - Write latency is 1 cycle.
// - Same-address collision:
//   - The highest agent index wins; table entry = max i.
//   - collision = 1 in the following cycle for exactly 1 cycle per colliding cycle.
//   - Distinct addresses never collide and are all updated in the same cycle.
// - Read lookup:
//   - rdselect[rd] = table[m_rdaddr_rd] combinationally, in the same cycle as the address.
//   - The read switch registers the selector itself.
//   - When m_rden[rd]=0 the output is don't-care, but it still tracks the table.
// - Read/write same address, same cycle:
//   - rdselect returns the pre-write value (read-first), consistent with read-first banks.
//   - The new owner is visible from the next cycle.
// - Widths:
//   - Agent index i is truncated to SELECT_WIDTH bits.
//   - The sweep counter is ADDR_WIDTH+1 bits; its MSB marks terminal count.
//   - No wrap-around occurs in RUN.
// STRUCTURE
// - Shared package meduram_pkg holds:
//   - typedef enum logic {INIT, RUN} lvt_state_t
//   - function sel_width(int nb) returning the selector width; SELECT_WIDTH uses the same formula.
// - Sub-module lvt_regfile:
//   - 2**ADDR_WIDTH x SELECT_WIDTH flop array, no reset on the array.
//   - NB_WRAGENT+1 write ports (agents + sweep) with a priority encoder: sweep > highest agent index.
//   - NB_RDAGENT asynchronous read ports.
// - Top level holds the FSM, sweep counter and collision detector (pairwise address compare on enabled writes).
// TESTING
// - Bench parameters: ADDR_WIDTH=4, NB_WRAGENT=4, NB_RDAGENT=2; every scenario starts after ready=1.
// - Reset release -> ready stays 0 for exactly 16 cycles, then 1. Reading all 16 addresses returns rdselect=0.
// - Agent 2 writes addr 5; next cycle rd0 reads addr 5 -> rdselect[0]=2.
//   - Meanwhile rd1 reads addr 6 -> rdselect[1]=0.
// - Agents 1 and 3 both write addr 9 in one cycle -> table[9]=3 and collision=1 for one cycle.
//   - Agents 0/1/2/3 write addrs 0/1/2/3 in one cycle -> each entry = its writer, collision stays 0.
// - Agent 1 writes addr 7 while rd0 reads addr 7 in the same cycle -> rdselect[0]=0 that cycle, =1 next cycle.
// - aresetn pulsed low for 1 cycle in RUN with table[5]=2:
//   - ready=0 and a fresh 16-cycle sweep; afterwards table[5]=0.
//   - Writes issued during the sweep are ignored.
// - Agent 3 writes addr 15, then agent 0 writes addr 15 a cycle later -> rdselect=3, then 0. No collision reported.

Source files
------------

// File: rtl/meduram_pkg.sv
// Shared types and helpers for the multi-port RAM live-value table.
package meduram_pkg;

  typedef enum logic {INIT, RUN} lvt_state_t;

  // A single bank still needs a 1-bit selector so ports never collapse to zero width.
  function automatic int sel_width(input int nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

endpackage

// File: rtl/lvt_regfile.sv
// Flop array holding the owning bank per address; agent and sweep write ports,
// combinational read ports.
module lvt_regfile #(
  parameter int AW    = 8,
  parameter int NB_WR = 2,
  parameter int NB_RD = 2,
  parameter int SW    = 1
) (
  input  logic               clk,
  input  logic               sweep_en,
  input  logic [AW-1:0]      sweep_addr,
  input  logic [NB_WR-1:0]   wr_en,
  input  logic [NB_WR*AW-1:0] wr_addr,
  input  logic [NB_RD*AW-1:0] rd_addr,
  output logic [NB_RD*SW-1:0] rd_data
);

  localparam int DEPTH = 2 ** AW;

  logic [SW-1:0]    mem [DEPTH];
  logic [DEPTH-1:0] hit;
  logic [SW-1:0]    val [DEPTH];

  // Per-entry priority encoder: later matches override earlier ones, so the
  // highest agent index wins and the sweep overrides every agent.
  always_comb begin
    hit = '0;
    for (int e = 0; e < DEPTH; e++) begin
      val[e] = '0;
      for (int i = 0; i < NB_WR; i++) begin
        if (wr_en[i] && (wr_addr[i*AW +: AW] == AW'(e))) begin
          hit[e] = 1'b1;
          val[e] = SW'(i);
        end
      end
      if (sweep_en && (sweep_addr == AW'(e))) begin
        hit[e] = 1'b1;
        val[e] = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int e = 0; e < DEPTH; e++) begin
      if (hit[e]) mem[e] <= val[e];
    end
  end

  for (genvar r = 0; r < NB_RD; r++) begin : g_rd
    assign rd_data[r*SW +: SW] = mem[rd_addr[r*AW +: AW]];
  end

endmodule

// File: rtl/write_accounter.sv
// Live-value table: tracks which write bank holds the latest data per address
// and feeds the read switch its bank selectors in the read-address cycle.
module write_accounter
  import meduram_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int NB_WRAGENT   = 2,
  parameter int NB_RDAGENT   = 2,
  parameter int SELECT_WIDTH = sel_width(NB_WRAGENT)
) (
  input  logic                               aclk,
  input  logic                               aresetn,
  output logic                               ready,
  input  logic [NB_WRAGENT-1:0]              m_wren,
  input  logic [NB_WRAGENT*ADDR_WIDTH-1:0]   m_wraddr,
  input  logic [NB_RDAGENT-1:0]              m_rden,
  input  logic [NB_RDAGENT*ADDR_WIDTH-1:0]   m_rdaddr,
  output logic [NB_RDAGENT*SELECT_WIDTH-1:0] rdselect,
  output logic                               collision
);

  lvt_state_t                      state, state_next;
  logic [ADDR_WIDTH:0]             counter, counter_next;
  logic                            sweep_en;
  logic [NB_WRAGENT-1:0]           agent_wren;
  logic                            collision_next;
  logic [NB_RDAGENT*SELECT_WIDTH-1:0] table_rd;

  // Read enables do not change the lookup: the selector always tracks the table.
  logic unused_rden;
  assign unused_rden = ^m_rden;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state     <= INIT;
      counter   <= '0;
      collision <= 1'b0;
    end else begin
      state     <= state_next;
      counter   <= counter_next;
      collision <= collision_next;
    end
  end

  // Counter MSB set means the sweep has covered every entry; it then holds.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    sweep_en     = 1'b0;
    agent_wren   = '0;
    case (state)
      INIT: begin
        if (!counter[ADDR_WIDTH]) begin
          sweep_en     = 1'b1;
          counter_next = counter + (ADDR_WIDTH+1)'(1);
          if (&counter[ADDR_WIDTH-1:0]) state_next = RUN;
        end
      end
      RUN: begin
        agent_wren = m_wren;
      end
      default: state_next = INIT;
    endcase
  end

  always_comb begin
    collision_next = 1'b0;
    if (state == RUN) begin
      for (int i = 0; i < NB_WRAGENT; i++) begin
        for (int j = i + 1; j < NB_WRAGENT; j++) begin
          if (m_wren[i] && m_wren[j] &&
              (m_wraddr[i*ADDR_WIDTH +: ADDR_WIDTH] == m_wraddr[j*ADDR_WIDTH +: ADDR_WIDTH]))
            collision_next = 1'b1;
        end
      end
    end
  end

  lvt_regfile #(
    .AW    (ADDR_WIDTH),
    .NB_WR (NB_WRAGENT),
    .NB_RD (NB_RDAGENT),
    .SW    (SELECT_WIDTH)
  ) u_regfile (
    .clk        (aclk),
    .sweep_en   (sweep_en),
    .sweep_addr (counter[ADDR_WIDTH-1:0]),
    .wr_en      (agent_wren),
    .wr_addr    (m_wraddr),
    .rd_addr    (m_rdaddr),
    .rd_data    (table_rd)
  );

  assign ready    = (state == RUN);
  assign rdselect = ready ? table_rd : '0;

endmodule

// File: tb/tb_write_accounter.sv
// Randomized and directed bench for write_accounter against a dictionary model
// of address ownership.
module tb_write_accounter;

  localparam int AW    = 4;
  localparam int NW    = 4;
  localparam int NR    = 2;
  localparam int SW    = 2;
  localparam int DEPTH = 16;
  localparam int EW    = 2 + NR*SW;

  logic              aclk = 1'b0;
  logic              aresetn = 1'b0;
  logic              ready;
  logic [NW-1:0]     m_wren = '0;
  logic [NW*AW-1:0]  m_wraddr = '0;
  logic [NR-1:0]     m_rden = '0;
  logic [NR*AW-1:0]  m_rdaddr = '0;
  logic [NR*SW-1:0]  rdselect;
  logic              collision;

  always #5 aclk = ~aclk;

  write_accounter #(
    .ADDR_WIDTH (AW),
    .NB_WRAGENT (NW),
    .NB_RDAGENT (NR)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .ready     (ready),
    .m_wren    (m_wren),
    .m_wraddr  (m_wraddr),
    .m_rden    (m_rden),
    .m_rdaddr  (m_rdaddr),
    .rdselect  (rdselect),
    .collision (collision)
  );

  logic [EW-1:0] exp_q[$];
  string         tag_q[$];
  int            tbl[DEPTH];
  bit            prev_coll = 1'b0;
  int            edges = 0;
  int            errors = 0;
  int            checks = 0;

  always @(posedge aclk or negedge aresetn) begin
    if (!aresetn) edges <= 0;
    else          edges <= edges + 1;
  end

  // Monitor: one expectation per driven cycle, compared mid-cycle.
  always @(negedge aclk) begin
    logic [EW-1:0] e;
    logic [EW-1:0] a;
    string t;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      a = {ready, collision, rdselect};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL %s @%0t: got ready=%b collision=%b rdselect=%h, need ready=%b collision=%b rdselect=%h",
                 t, $time, a[EW-1], a[EW-2], a[NR*SW-1:0], e[EW-1], e[EW-2], e[NR*SW-1:0]);
      end
    end
  end

  function automatic logic [NW*AW-1:0] wa(input int a0, input int a1, input int a2, input int a3);
    return {AW'(a3), AW'(a2), AW'(a1), AW'(a0)};
  endfunction

  function automatic logic [NR*AW-1:0] ra(input int a0, input int a1);
    return {AW'(a1), AW'(a0)};
  endfunction

  task automatic drive_cycle(input string tag, input logic [NW-1:0] wren,
                             input logic [NW*AW-1:0] wraddr, input logic [NR-1:0] rden,
                             input logic [NR*AW-1:0] rdaddr);
    bit               rdy;
    bit               coll;
    logic [NR*SW-1:0] sel;
    int               hits[DEPTH];
    @(posedge aclk); #1;
    m_wren   = wren;
    m_wraddr = wraddr;
    m_rden   = rden;
    m_rdaddr = rdaddr;
    rdy = (aresetn == 1'b1) && (edges >= DEPTH);
    sel = '0;
    if (rdy)
      for (int r = 0; r < NR; r++) sel[r*SW +: SW] = SW'(tbl[int'(rdaddr[r*AW +: AW])]);
    exp_q.push_back({rdy, prev_coll, sel});
    tag_q.push_back(tag);
    coll = 1'b0;
    foreach (hits[k]) hits[k] = 0;
    if (rdy) begin
      for (int i = 0; i < NW; i++) begin
        if (wren[i]) begin
          int a;
          a = int'(wraddr[i*AW +: AW]);
          hits[a]++;
          if (hits[a] > 1) coll = 1'b1;
          if (hits[a] == 1 || i > tbl[a]) tbl[a] = i;
        end
      end
    end
    prev_coll = coll;
  endtask

  task automatic pulse_reset();
    @(posedge aclk); #1;
    aresetn = 1'b0;
    exp_q.push_back('0);
    tag_q.push_back("reset_state");
    prev_coll = 1'b0;
    foreach (tbl[k]) tbl[k] = 0;
    @(posedge aclk); #1;
    aresetn = 1'b1;
  endtask

  task automatic sweep_with_noise(input string tag);
    for (int c = 0; c < DEPTH; c++)
      drive_cycle(tag, NW'($urandom_range(0, 15)), (NW*AW)'($urandom_range(0, 65535)),
                  NR'($urandom_range(0, 3)), ra($urandom_range(0, 15), $urandom_range(0, 15)));
  endtask

  initial begin
    pulse_reset();
    sweep_with_noise("sweep_ready");
    for (int a = 0; a < DEPTH; a += 2)
      drive_cycle("cleared_table", '0, '0, 2'b11, ra(a, a + 1));

    drive_cycle("wr_a2_addr5", 4'b0100, wa(0, 0, 5, 0), 2'b00, ra(5, 6));
    drive_cycle("rd_addr5_6",  4'b0000, wa(0, 0, 0, 0), 2'b11, ra(5, 6));

    drive_cycle("coll_addr9",  4'b1010, wa(0, 9, 0, 9), 2'b11, ra(9, 9));
    drive_cycle("coll_pulse",  4'b0000, wa(0, 0, 0, 0), 2'b11, ra(9, 9));
    drive_cycle("coll_clear",  4'b0000, wa(0, 0, 0, 0), 2'b11, ra(9, 0));

    drive_cycle("wr_distinct", 4'b1111, wa(0, 1, 2, 3), 2'b11, ra(0, 1));
    drive_cycle("rd_addr0_1",  4'b0000, wa(0, 0, 0, 0), 2'b11, ra(0, 1));
    drive_cycle("rd_addr2_3",  4'b0000, wa(0, 0, 0, 0), 2'b11, ra(2, 3));

    drive_cycle("rw_first7",   4'b0010, wa(0, 7, 0, 0), 2'b01, ra(7, 7));
    drive_cycle("rd_after7",   4'b0000, wa(0, 0, 0, 0), 2'b11, ra(7, 7));

    drive_cycle("wr_a2_addr5b", 4'b0100, wa(0, 0, 5, 0), 2'b11, ra(5, 5));
    drive_cycle("rd_addr5_pre", 4'b0000, wa(0, 0, 0, 0), 2'b11, ra(5, 5));
    pulse_reset();
    sweep_with_noise("resweep");
    drive_cycle("rd_addr5_post", 4'b0000, wa(0, 0, 0, 0), 2'b11, ra(5, 7));

    drive_cycle("wr_a3_addr15", 4'b1000, wa(0, 0, 0, 15), 2'b11, ra(15, 15));
    drive_cycle("wr_a0_addr15", 4'b0001, wa(15, 0, 0, 0), 2'b11, ra(15, 15));
    drive_cycle("rd_addr15",    4'b0000, wa(0, 0, 0, 0), 2'b11, ra(15, 15));
    drive_cycle("rd_addr15b",   4'b0000, wa(0, 0, 0, 0), 2'b11, ra(15, 0));

    for (int n = 0; n < 400; n++) begin
      int lim;
      if (n == 200) begin
        pulse_reset();
        sweep_with_noise("rand_sweep");
      end
      lim = (n % 3 == 0) ? 3 : 15;
      drive_cycle("random", NW'($urandom_range(0, 15)),
                  wa($urandom_range(0, lim), $urandom_range(0, lim),
                     $urandom_range(0, lim), $urandom_range(0, lim)),
                  NR'($urandom_range(0, 3)),
                  ra($urandom_range(0, lim), $urandom_range(0, 15)));
    end
    drive_cycle("drain", '0, '0, 2'b00, ra(0, 0));

    @(negedge aclk);
    @(negedge aclk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, need 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
